multi_cycle_ctrl: RTL and testbench

//  Multi-cycle control unit: sequences the datapath (PC, IR, register file, Extend,
//  ALU, data memory) through IF/ID/EXE/MEM/WB, one state per clock.

---
 rtl/multi_cycle_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit: steps the datapath through IF/ID/EXE/MEM/WB one
// state per clock, decodes the IR opcode and counts retired instructions.
module multi_cycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWre,
    output logic [1:0]       PCSrc,
    output logic             IRWre,
    output logic             ExtSel,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             RegDst,
    output logic             RegWre,
    output logic             DBDataSrc,
    output logic             mRD,
    output logic             mWR,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCnt
);

    typedef enum logic [3:0] {
        sIf    = 4'b0000,
        sId    = 4'b0001,
        sExeLs = 4'b0010,
        sMem   = 4'b0011,
        sWbL   = 4'b0100,
        sExeBr = 4'b0101,
        sExeAl = 4'b0110,
        sWbAl  = 4'b0111,
        sHalt  = 4'b1000
    } state_t;

    typedef enum logic [5:0] {
        opAdd   = 6'b000000,
        opSub   = 6'b000001,
        opAddiu = 6'b000010,
        opAnd   = 6'b010000,
        opAndi  = 6'b010001,
        opOri   = 6'b010010,
        opSlt   = 6'b100110,
        opSw    = 6'b110000,
        opLw    = 6'b110001,
        opBeq   = 6'b110100,
        opJ     = 6'b111000,
        opHalt  = 6'b111111
    } opcode_t;

    state_t state;

    logic isAlu;
    logic isLoad;
    logic isStore;
    logic isBranch;
    logic isJump;
    logic isHalt;

    logic       pcWre;
    logic [1:0] pcSrc;
    logic       irWre;
    logic       regWre;
    logic       memRd;
    logic       memWr;

    // Opcode classification and the Op-only decode outputs
    always_comb begin
        isAlu     = 1'b0;
        isLoad    = 1'b0;
        isStore   = 1'b0;
        isBranch  = 1'b0;
        isJump    = 1'b0;
        isHalt    = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        RegDst    = 1'b0;
        DBDataSrc = 1'b0;
        case (Op)
            opAdd: begin
                isAlu  = 1'b1;
                RegDst = 1'b1;
            end
            opSub: begin
                isAlu  = 1'b1;
                RegDst = 1'b1;
                ALUOp  = 3'b001;
            end
            opAddiu: begin
                isAlu   = 1'b1;
                ExtSel  = 1'b1;
                ALUSrcB = 1'b1;
            end
            opAnd: begin
                isAlu  = 1'b1;
                RegDst = 1'b1;
                ALUOp  = 3'b100;
            end
            opAndi: begin
                isAlu   = 1'b1;
                ALUSrcB = 1'b1;
                ALUOp   = 3'b100;
            end
            opOri: begin
                isAlu   = 1'b1;
                ALUSrcB = 1'b1;
                ALUOp   = 3'b011;
            end
            opSlt: begin
                isAlu  = 1'b1;
                RegDst = 1'b1;
                ALUOp  = 3'b010;
            end
            opSw: begin
                isStore = 1'b1;
                ExtSel  = 1'b1;
                ALUSrcB = 1'b1;
            end
            opLw: begin
                isLoad    = 1'b1;
                ExtSel    = 1'b1;
                ALUSrcB   = 1'b1;
                DBDataSrc = 1'b1;
            end
            opBeq: begin
                isBranch = 1'b1;
                ExtSel   = 1'b1;
                ALUOp    = 3'b001;
            end
            opJ:     isJump = 1'b1;
            opHalt:  isHalt = 1'b1;
            default: ;
        endcase
    end

    // State-gated strobes; PCWre marks the final cycle of every instruction
    always_comb begin
        pcWre  = 1'b0;
        pcSrc  = 2'b00;
        irWre  = 1'b0;
        regWre = 1'b0;
        memRd  = 1'b0;
        memWr  = 1'b0;
        case (state)
            sIf: irWre = 1'b1;
            sId: begin
                if (isJump) begin
                    pcWre = 1'b1;
                    pcSrc = 2'b10;
                end else if (!(isAlu || isLoad || isStore || isBranch || isHalt)) begin
                    pcWre = 1'b1;
                end
            end
            sExeBr: begin
                pcWre = 1'b1;
                if (Zero) pcSrc = 2'b01;
            end
            sWbAl, sWbL: begin
                pcWre  = 1'b1;
                regWre = 1'b1;
            end
            sMem: begin
                memRd = isLoad;
                memWr = isStore;
                pcWre = isStore && MemReady;
            end
            default: ;
        endcase
    end

    // Write enables are masked directly by Reset so they drop without a clock
    assign PCWre  = pcWre && Reset;
    assign PCSrc  = pcSrc;
    assign IRWre  = irWre && Reset;
    assign RegWre = regWre && Reset;
    assign mRD    = memRd && Reset;
    assign mWR    = memWr && Reset;
    assign Halted = (state == sHalt);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= sIf;
            InstrCnt <= '0;
        end else begin
            if (pcWre && (InstrCnt != '1))
                InstrCnt <= InstrCnt + CNT_W'(1);
            case (state)
                sIf: state <= sId;
                sId: begin
                    if (isJump)                 state <= sIf;
                    else if (isHalt)            state <= sHalt;
                    else if (isBranch)          state <= sExeBr;
                    else if (isLoad || isStore) state <= sExeLs;
                    else if (isAlu)             state <= sExeAl;
                    else                        state <= sIf;
                end
                sExeAl: state <= sWbAl;
                sWbAl:  state <= sIf;
                sExeBr: state <= sIf;
                sExeLs: state <= sMem;
                sMem: begin
                    if (MemReady) state <= isLoad ? sWbL : sIf;
                end
                sWbL:   state <= sIf;
                sHalt:  state <= sHalt;
                default: state <= sIf;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle expected strobes, decode
// fields and retired count; a 3-bit counter exposes saturation.
module tb_multi_cycle_ctrl;

    localparam int unsigned CW = 3;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [5:0]    Op;
    logic          Zero;
    logic          MemReady;
    logic          PCWre;
    logic [1:0]    PCSrc;
    logic          IRWre;
    logic          ExtSel;
    logic          ALUSrcB;
    logic [2:0]    ALUOp;
    logic          RegDst;
    logic          RegWre;
    logic          DBDataSrc;
    logic          mRD;
    logic          mWR;
    logic          Halted;
    logic [CW-1:0] InstrCnt;

    multi_cycle_ctrl #(.CNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre),
        .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .Halted(Halted),
        .InstrCnt(InstrCnt)
    );

    always #5 CLK = ~CLK;

    // {PCWre, PCSrc, IRWre, RegWre, mRD, mWR, Halted}
    logic [7:0] ctl;
    // {ExtSel, ALUSrcB, ALUOp, RegDst, DBDataSrc}
    logic [6:0] dec;
    assign ctl = {PCWre, PCSrc, IRWre, RegWre, mRD, mWR, Halted};
    assign dec = {ExtSel, ALUSrcB, ALUOp, RegDst, DBDataSrc};

    localparam logic [7:0] cNone = 8'b0_00_0_0_0_0_0;
    localparam logic [7:0] cIf   = 8'b0_00_1_0_0_0_0;
    localparam logic [7:0] cJmp  = 8'b1_10_0_0_0_0_0;
    localparam logic [7:0] cRet  = 8'b1_00_0_0_0_0_0;
    localparam logic [7:0] cBrT  = 8'b1_01_0_0_0_0_0;
    localparam logic [7:0] cWb   = 8'b1_00_0_1_0_0_0;
    localparam logic [7:0] cRd   = 8'b0_00_0_0_1_0_0;
    localparam logic [7:0] cWrOk = 8'b1_00_0_0_0_1_0;
    localparam logic [7:0] cHalt = 8'b0_00_0_0_0_0_1;

    localparam logic [6:0] dAdd   = 7'b0_0_000_1_0;
    localparam logic [6:0] dSub   = 7'b0_0_001_1_0;
    localparam logic [6:0] dAddiu = 7'b1_1_000_0_0;
    localparam logic [6:0] dAnd   = 7'b0_0_100_1_0;
    localparam logic [6:0] dAndi  = 7'b0_1_100_0_0;
    localparam logic [6:0] dOri   = 7'b0_1_011_0_0;
    localparam logic [6:0] dSlt   = 7'b0_0_010_1_0;
    localparam logic [6:0] dSw    = 7'b1_1_000_0_0;
    localparam logic [6:0] dLw    = 7'b1_1_000_0_1;
    localparam logic [6:0] dBeq   = 7'b1_0_001_0_0;
    localparam logic [6:0] dZero  = 7'b0_0_000_0_0;

    typedef struct {
        logic [5:0]    op;
        logic          zero;
        logic          rdy;
        logic [7:0]    ctl;
        logic [6:0]    dec;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t  vecs[$];
    string tags[$];
    int    nChecks = 0;
    int    nErrors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pushVec(input string tag, input logic [5:0] op, input logic zero,
                           input logic rdy, input logic [7:0] c, input logic [6:0] d,
                           input logic [CW-1:0] cnt);
        vec_t v;
        v.op = op; v.zero = zero; v.rdy = rdy; v.ctl = c; v.dec = d; v.cnt = cnt;
        vecs.push_back(v);
        tags.push_back(tag);
    endtask

    // Called at posedge+1; each entry is one clock cycle of the instruction stream
    task automatic runVecs();
        foreach (vecs[i]) begin
            Op = vecs[i].op;
            Zero = vecs[i].zero;
            MemReady = vecs[i].rdy;
            #3;
            checkVal($sformatf("%s#%0d.ctl", tags[i], i), 32'(ctl), 32'(vecs[i].ctl));
            checkVal($sformatf("%s#%0d.dec", tags[i], i), 32'(dec), 32'(vecs[i].dec));
            checkVal($sformatf("%s#%0d.cnt", tags[i], i), 32'(InstrCnt), 32'(vecs[i].cnt));
            @(posedge CLK);
            #1;
        end
        vecs.delete();
        tags.delete();
    endtask

    initial begin
        Reset = 1'b0;
        Op = 6'b000000;
        Zero = 1'b0;
        MemReady = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checkVal("rst.ctl", 32'(ctl), 32'(cNone));
        checkVal("rst.cnt", 32'(InstrCnt), 0);
        Reset = 1'b1;

        pushVec("add", 6'b000000, 0, 0, cIf,  dAdd, 0);
        pushVec("add", 6'b000000, 0, 0, cNone, dAdd, 0);
        pushVec("add", 6'b000000, 0, 0, cNone, dAdd, 0);
        pushVec("add", 6'b000000, 0, 0, cWb,  dAdd, 0);
        pushVec("ori", 6'b010010, 0, 0, cIf,  dOri, 1);
        pushVec("ori", 6'b010010, 0, 0, cNone, dOri, 1);
        pushVec("ori", 6'b010010, 0, 0, cNone, dOri, 1);
        pushVec("ori", 6'b010010, 0, 0, cWb,  dOri, 1);
        pushVec("addiu", 6'b000010, 0, 0, cIf,  dAddiu, 2);
        pushVec("addiu", 6'b000010, 0, 0, cNone, dAddiu, 2);
        pushVec("addiu", 6'b000010, 0, 0, cNone, dAddiu, 2);
        pushVec("addiu", 6'b000010, 0, 0, cWb,  dAddiu, 2);
        pushVec("beqT", 6'b110100, 1, 0, cIf,  dBeq, 3);
        pushVec("beqT", 6'b110100, 1, 0, cNone, dBeq, 3);
        pushVec("beqT", 6'b110100, 1, 0, cBrT, dBeq, 3);
        pushVec("beqN", 6'b110100, 0, 0, cIf,  dBeq, 4);
        pushVec("beqN", 6'b110100, 0, 0, cNone, dBeq, 4);
        pushVec("beqN", 6'b110100, 0, 0, cRet, dBeq, 4);
        pushVec("lw", 6'b110001, 0, 0, cIf,  dLw, 5);
        pushVec("lw", 6'b110001, 0, 0, cNone, dLw, 5);
        pushVec("lw", 6'b110001, 0, 0, cNone, dLw, 5);
        pushVec("lw", 6'b110001, 0, 0, cRd,  dLw, 5);
        pushVec("lw", 6'b110001, 0, 0, cRd,  dLw, 5);
        pushVec("lw", 6'b110001, 0, 0, cRd,  dLw, 5);
        pushVec("lw", 6'b110001, 0, 1, cRd,  dLw, 5);
        pushVec("lw", 6'b110001, 0, 0, cWb,  dLw, 5);
        pushVec("sw", 6'b110000, 0, 1, cIf,  dSw, 6);
        pushVec("sw", 6'b110000, 0, 1, cNone, dSw, 6);
        pushVec("sw", 6'b110000, 0, 1, cNone, dSw, 6);
        pushVec("sw", 6'b110000, 0, 1, cWrOk, dSw, 6);
        pushVec("j", 6'b111000, 0, 0, cIf,  dZero, 7);
        pushVec("j", 6'b111000, 0, 0, cJmp, dZero, 7);
        pushVec("nop", 6'b000011, 0, 0, cIf,  dZero, 7);
        pushVec("nop", 6'b000011, 0, 0, cRet, dZero, 7);
        pushVec("sub", 6'b000001, 0, 0, cIf,  dSub, 7);
        pushVec("sub", 6'b000001, 0, 0, cNone, dSub, 7);
        pushVec("sub", 6'b000001, 0, 0, cNone, dSub, 7);
        pushVec("sub", 6'b000001, 0, 0, cWb,  dSub, 7);
        pushVec("and", 6'b010000, 0, 0, cIf,  dAnd, 7);
        pushVec("andi", 6'b010001, 0, 0, cNone, dAndi, 7);
        pushVec("slt", 6'b100110, 0, 0, cNone, dSlt, 7);
        pushVec("slt", 6'b100110, 0, 0, cWb,  dSlt, 7);
        pushVec("halt", 6'b111111, 0, 0, cIf,  dZero, 7);
        pushVec("halt", 6'b111111, 0, 0, cNone, dZero, 7);
        pushVec("halt", 6'b111111, 0, 0, cHalt, dZero, 7);
        pushVec("halt", 6'b111111, 0, 1, cHalt, dZero, 7);
        pushVec("halt", 6'b111111, 0, 0, cHalt, dZero, 7);
        runVecs();

        Reset = 1'b0;
        #1;
        checkVal("haltRst.ctl", 32'(ctl), 32'(cNone));
        checkVal("haltRst.cnt", 32'(InstrCnt), 0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;

        pushVec("lwRst", 6'b110001, 0, 0, cIf,  dLw, 0);
        pushVec("lwRst", 6'b110001, 0, 0, cNone, dLw, 0);
        pushVec("lwRst", 6'b110001, 0, 0, cNone, dLw, 0);
        pushVec("lwRst", 6'b110001, 0, 0, cRd,  dLw, 0);
        runVecs();
        checkVal("midRst.pre", 32'(ctl), 32'(cRd));
        Reset = 1'b0;
        #1;
        checkVal("midRst.ctl", 32'(ctl), 32'(cNone));
        checkVal("midRst.cnt", 32'(InstrCnt), 0);
        @(posedge CLK);
        #1;
        checkVal("midRst.hold", 32'(ctl), 32'(cNone));
        Reset = 1'b1;

        pushVec("after", 6'b110001, 0, 0, cIf,  dLw, 0);
        pushVec("after", 6'b110001, 0, 0, cNone, dLw, 0);
        runVecs();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
